// File: rtl/fetch_pair_queue_pkg.sv
// Shared definitions for the fetch pair queue and the dual-issue relayer:
// NOP encoding, instruction field positions and the default queue depth.
package fetch_pair_queue_pkg;

  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned INSTR_W       = 16;
  localparam int unsigned PC_W          = 16;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned IMM_BIT = 11;
  localparam int unsigned RD_MSB  = 10;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 5;
  localparam int unsigned RS2_MSB = 4;
  localparam int unsigned RS2_LSB = 2;

  typedef struct packed {
    logic [3:0] opcode;
    logic       imm;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [1:0] rsvd;
  } instr_fields_t;

  typedef enum logic [1:0] {
    POP_NONE      = 2'd0,
    POP_ONE       = 2'd1,
    POP_TWO       = 2'd2,
    POP_TWO_ALIAS = 2'd3
  } pop_req_e;

  // The relayer never consumes more than two; code 3 is treated as two.
  function automatic logic [1:0] pop_clamp(input pop_req_e req);
    logic [1:0] n;
    n = 2'd0;
    case (req)
      POP_NONE:      n = 2'd0;
      POP_ONE:       n = 2'd1;
      POP_TWO:       n = 2'd2;
      POP_TWO_ALIAS: n = 2'd2;
      default:       n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_queue_store.sv
// DEPTH x 16 register file for the fetch queue: two write ports, two
// combinational read ports, asynchronously cleared to NOP.
module fetch_queue_store
  import fetch_pair_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we0,
  input  logic [AW-1:0]      i_waddr0,
  input  logic [INSTR_W-1:0] i_wdata0,
  input  logic               i_we1,
  input  logic [AW-1:0]      i_waddr1,
  input  logic [INSTR_W-1:0] i_wdata1,
  input  logic [AW-1:0]      i_raddr0,
  input  logic [AW-1:0]      i_raddr1,
  output logic [INSTR_W-1:0] o_rdata0,
  output logic [INSTR_W-1:0] o_rdata1
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= NOP;
      end
    end else begin
      if (i_we0) r_mem[i_waddr0] <= i_wdata0;
      if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_pair_queue.sv
// Instruction fetch queue: fetches two words per cycle into a circular
// buffer and presents the two oldest entries to the dual-issue relayer.
module fetch_pair_queue
  import fetch_pair_queue_pkg::*;
#(
  parameter int unsigned    DEPTH    = DEPTH_DEFAULT,
  parameter logic [PC_W-1:0] PC_RESET = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]         imem_rdata0,
  input  logic [INSTR_W-1:0]         imem_rdata1,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic [1:0]                 pop_cnt,
  output logic [INSTR_W-1:0]         instr1_o,
  output logic [INSTR_W-1:0]         instr2_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] PUSH_MAX = CW'(DEPTH - 2);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_pair_queue: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [PC_W-1:0]    r_pc;

  logic               w_push;
  logic [1:0]         w_pop_req;
  logic [CW-1:0]      w_pop_eff;
  logic [CW-1:0]      w_push_amt;
  logic [AW-1:0]      w_wr_ptr1;
  logic [AW-1:0]      w_rd_ptr1;
  logic [INSTR_W-1:0] w_rdata0;
  logic [INSTR_W-1:0] w_rdata1;

  assign w_push     = fetch_en && !redirect_valid && (r_count <= PUSH_MAX);
  assign w_pop_req  = pop_clamp(pop_req_e'(pop_cnt));
  assign w_pop_eff  = (CW'(w_pop_req) > r_count) ? r_count : CW'(w_pop_req);
  assign w_push_amt = w_push ? CW'(2) : '0;
  assign w_wr_ptr1  = r_wr_ptr + AW'(1);
  assign w_rd_ptr1  = r_rd_ptr + AW'(1);

  // Redirect outranks push and pop; stale entries are left in place and
  // hidden by the zeroed count rather than cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_pc     <= PC_RESET;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_pc     <= redirect_pc;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(w_pop_eff);
      r_count  <= r_count + w_push_amt - w_pop_eff;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(2);
        r_pc     <= r_pc + PC_W'(2);
      end
    end
  end

  fetch_queue_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .i_we0    (w_push),
    .i_waddr0 (r_wr_ptr),
    .i_wdata0 (imem_rdata0),
    .i_we1    (w_push),
    .i_waddr1 (w_wr_ptr1),
    .i_wdata1 (imem_rdata1),
    .i_raddr0 (r_rd_ptr),
    .i_raddr1 (w_rd_ptr1),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1)
  );

  always_comb begin
    instr1_o = NOP;
    instr2_o = NOP;
    if (r_count >= CW'(1)) instr1_o = w_rdata0;
    if (r_count >= CW'(2)) instr2_o = w_rdata1;
  end

  assign imem_addr = r_pc;
  assign count_o   = r_count;

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed and randomized bench for fetch_pair_queue against a queue-based
// reference model of the fetch/pop/redirect rules.
module tb_fetch_pair_queue;

  localparam int unsigned DEPTH    = 8;
  localparam logic [15:0] PC_RESET = 16'h0000;
  localparam logic [15:0] NOPW     = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata0;
  logic [15:0] imem_rdata1;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [1:0]  pop_cnt;
  logic [15:0] instr1_o;
  logic [15:0] instr2_o;
  logic [3:0]  count_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic [15:0] mpc;

  always #5 clk = ~clk;

  function automatic logic [15:0] imem_word(input logic [15:0] a);
    logic [15:0] t;
    t = a + 16'd1;
    return 16'h1111 * t;
  endfunction

  assign imem_rdata0 = imem_word(imem_addr);
  assign imem_rdata1 = imem_word(imem_addr + 16'd1);

  fetch_pair_queue #(
    .DEPTH    (DEPTH),
    .PC_RESET (PC_RESET)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata0    (imem_rdata0),
    .imem_rdata1    (imem_rdata1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pop_cnt        (pop_cnt),
    .instr1_o       (instr1_o),
    .instr2_o       (instr2_o),
    .count_o        (count_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [15:0] e1, e2;
    e1 = (mq.size() >= 1) ? mq[0] : NOPW;
    e2 = (mq.size() >= 2) ? mq[1] : NOPW;
    chk({tag, ".instr1"}, instr1_o, e1);
    chk({tag, ".instr2"}, instr2_o, e2);
    chk({tag, ".count"}, {12'd0, count_o}, 16'(mq.size()));
    chk({tag, ".addr"}, imem_addr, mpc);
  endtask

  // Apply inputs for one cycle, advance the model, then check after the edge.
  task automatic step(input logic fe, input logic rv, input logic [15:0] rpc,
                      input logic [1:0] pop, input string tag);
    int unsigned req, eff;
    bit do_push;
    fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; pop_cnt = pop;
    if (rv) begin
      mq.delete();
      mpc = rpc;
    end else begin
      req = (pop == 2'd3) ? 2 : int'(pop);
      eff = (req > mq.size()) ? mq.size() : req;
      do_push = fe && (mq.size() <= DEPTH - 2);
      repeat (eff) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(imem_word(mpc));
        mq.push_back(imem_word(mpc + 16'd1));
        mpc = mpc + 16'd2;
      end
    end
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; pop_cnt = 2'd0;
    mpc = PC_RESET;
    #1;
    chk_model("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill from reset with no consumption.
    step(1'b1, 1'b0, 16'h0, 2'd0, "fill1");
    chk("fill1.i1", instr1_o, 16'h1111);
    chk("fill1.i2", instr2_o, 16'h2222);
    chk("fill1.cnt", {12'd0, count_o}, 16'd2);
    repeat (3) step(1'b1, 1'b0, 16'h0, 2'd0, "fill");
    chk("full.cnt", {12'd0, count_o}, 16'd8);
    chk("full.addr", imem_addr, 16'h0008);
    step(1'b1, 1'b0, 16'h0, 2'd0, "stall");
    chk("stall.addr", imem_addr, 16'h0008);

    // Steady-state streaming with double pops.
    repeat (5) step(1'b1, 1'b0, 16'h0, 2'd2, "stream");
    repeat (2) step(1'b1, 1'b0, 16'h0, 2'd3, "pop3");

    // Drain down to one entry, then over-request a pop.
    repeat (4) step(1'b0, 1'b0, 16'h0, 2'd2, "drain");
    step(1'b1, 1'b0, 16'h0, 2'd0, "refill");
    step(1'b0, 1'b0, 16'h0, 2'd1, "pop1");
    chk("one.cnt", {12'd0, count_o}, 16'd1);
    step(1'b0, 1'b0, 16'h0, 2'd2, "underpop");
    chk("underpop.cnt", {12'd0, count_o}, 16'd0);
    chk("underpop.i1", instr1_o, NOPW);
    chk("underpop.i2", instr2_o, NOPW);

    // Redirect while holding six entries.
    repeat (3) step(1'b1, 1'b0, 16'h0, 2'd0, "fill6");
    chk("six.cnt", {12'd0, count_o}, 16'd6);
    step(1'b1, 1'b1, 16'h0040, 2'd2, "redir");
    chk("redir.cnt", {12'd0, count_o}, 16'd0);
    chk("redir.addr", imem_addr, 16'h0040);
    step(1'b1, 1'b0, 16'h0, 2'd0, "postredir");
    chk("postredir.i1", instr1_o, imem_word(16'h0040));
    chk("postredir.i2", instr2_o, imem_word(16'h0041));

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 16'hFFFF, 2'd0, "wrapredir");
    step(1'b1, 1'b0, 16'h0, 2'd0, "wrap");
    chk("wrap.i1", instr1_o, imem_word(16'hFFFF));
    chk("wrap.i2", instr2_o, imem_word(16'h0000));
    chk("wrap.addr", imem_addr, 16'h0001);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           16'($urandom), 2'($urandom), "rand");
    end

    // Build count=5, then reset asynchronously mid-cycle.
    step(1'b1, 1'b1, 16'h0100, 2'd0, "pre5");
    repeat (3) step(1'b1, 1'b0, 16'h0, 2'd0, "fill5");
    step(1'b0, 1'b0, 16'h0, 2'd1, "five");
    chk("five.cnt", {12'd0, count_o}, 16'd5);
    #2;
    rst = 1'b1;
    mq.delete();
    mpc = PC_RESET;
    #1;
    chk_model("asyncrst");
    @(posedge clk);
    #1;
    chk_model("rsthold");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.addr", imem_addr, PC_RESET);
    step(1'b1, 1'b0, 16'h0, 2'd0, "restart");
    chk("restart.i1", instr1_o, 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
